// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch-side req/addr_ok/data_ok handshake between pre-fetch and icache_dm
interface icache_dm_if #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 20
);
  logic             req;
  logic [IDX_W-1:0] index;
  logic [3:0]       offset;
  logic [TAG_W-1:0] ptag;
  logic             uncached;
  logic             addr_ok;
  logic             data_ok;
  logic [31:0]      rdata;

  modport master (output req, index, offset, ptag, uncached, input addr_ok, data_ok, rdata);
  modport slave  (input req, index, offset, ptag, uncached, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped VIPT instruction cache with line refill and uncached single-word fetch
module icache_dm #(
  parameter int SETS   = 256,
  parameter int LINE_W = 4,
  parameter int TAG_W  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  icache_dm_if.slave              bus,
  input  logic                    inv_valid,
  input  logic [$clog2(SETS)-1:0] inv_index,
  output logic                    inv_ready,
  output logic                    rd_req,
  output logic                    rd_type,
  output logic [31:0]             rd_addr,
  input  logic                    rd_rdy,
  input  logic                    ret_valid,
  input  logic                    ret_last,
  input  logic [31:0]             ret_data
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WSEL_W = $clog2(LINE_W);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;

  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS*LINE_W];

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [3:0]        offset_q, offset_d;
  logic [TAG_W-1:0]  ptag_q, ptag_d;
  logic              uncached_q, uncached_d;
  logic [WSEL_W-1:0] cnt_q, cnt_d;
  logic [31:0]       cap_q, cap_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              vld_rd_q, vld_rd_d;
  logic [TAG_W-1:0]  tag_rd_q, tag_rd_d;
  logic [31:0]       word_rd_q, word_rd_d;

  logic              hit;
  logic              accept;
  logic              data_we;
  logic              tag_we;
  logic [WSEL_W-1:0] want_beat;

  always_comb begin
    hit       = (state_q == LOOKUP) && vld_rd_q && (tag_rd_q == bus.ptag) && !bus.uncached && !reset;
    accept    = 1'b0;
    unique case (state_q)
      IDLE:    accept = bus.req && !inv_valid && !reset;
      LOOKUP:  accept = bus.req && hit;
      default: accept = 1'b0;
    endcase
    want_beat = uncached_q ? '0 : offset_q[WSEL_W+1:2];

    state_d    = state_q;
    valid_d    = valid_q;
    index_d    = index_q;
    offset_d   = offset_q;
    ptag_d     = ptag_q;
    uncached_d = uncached_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    vld_rd_d   = vld_rd_q;
    tag_rd_d   = tag_rd_q;
    word_rd_d  = word_rd_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;

    // Synchronous array read: sample on the accept cycle, consume in LOOKUP.
    if (accept) begin
      index_d   = bus.index;
      offset_d  = bus.offset;
      vld_rd_d  = valid_q[bus.index];
      tag_rd_d  = tag_mem[bus.index];
      word_rd_d = data_mem[{bus.index, bus.offset[WSEL_W+1:2]}];
    end

    unique case (state_q)
      IDLE: begin
        if (inv_valid) valid_d[inv_index] = 1'b0;
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        ptag_d     = bus.ptag;
        uncached_d = bus.uncached;
        if (!hit) state_d = MISS;
        else if (!accept) state_d = IDLE;
      end
      MISS: begin
        if (rd_rdy) state_d = REFILL;
      end
      REFILL: begin
        if (ret_valid) begin
          data_we = !uncached_q && !reset;
          if (cnt_q == want_beat) cap_d = ret_data;
          if (cnt_q != '1) cnt_d = cnt_q + WSEL_W'(1);
          if (ret_last) begin
            tag_we = !uncached_q && !reset;
            if (!uncached_q) valid_d[index_q] = 1'b1;
            cnt_d   = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    bus.addr_ok = accept;
    bus.data_ok = hit || ((state_q == RESP) && !reset);
    if (hit) bus.rdata = word_rd_q;
    else if (bus.data_ok) bus.rdata = cap_q;
    else bus.rdata = rdata_q;
    rdata_d = bus.rdata;

    inv_ready = (state_q == IDLE) && !reset;
    rd_req    = (state_q == MISS) && !reset;
    rd_type   = !uncached_q;
    rd_addr   = uncached_q ? {ptag_q, index_q, offset_q} : {ptag_q, index_q, 4'b0000};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      index_q    <= '0;
      offset_q   <= '0;
      ptag_q     <= '0;
      uncached_q <= 1'b0;
      cnt_q      <= '0;
      cap_q      <= '0;
      rdata_q    <= '0;
      vld_rd_q   <= 1'b0;
      tag_rd_q   <= '0;
      word_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      index_q    <= index_d;
      offset_q   <= offset_d;
      ptag_q     <= ptag_d;
      uncached_q <= uncached_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      vld_rd_q   <= vld_rd_d;
      tag_rd_q   <= tag_rd_d;
      word_rd_q  <= word_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[{index_q, cnt_q}] <= ret_data;
    if (tag_we) tag_mem[index_q] <= ptag_q;
  end

  // A line is at most LINE_W beats; a beat past the last slot must close the burst.
  assert property (@(posedge clk) disable iff (reset)
    !(state_q == REFILL && ret_valid && cnt_q == '1 && !ret_last));
endmodule
